// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - word-organised data memory with byte/half/word access and request/done handshake
// Little-endian 32-bit words; loads sign/zero-extend, stores use byte-lane merge; optional clear sweep after reset.
module data_mem_unit #(
   parameter int    ADDR_W         = 10,
   parameter int    LATENCY        = 0,
   parameter bit    CLEAR_ON_RESET = 1'b1,
   parameter string INIT_FILE      = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wData,
   output logic        o_ready,
   output logic        o_done,
   output logic [31:0] o_rData,
   output logic        o_err,
   output logic        o_busy
);

   localparam int DEPTH = 1 << (ADDR_W - 2);
   localparam int IDX_W = ADDR_W - 2;

   localparam logic [1:0] S_INIT = 2'd0;
   localparam logic [1:0] S_IDLE = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;
   localparam logic [1:0] S_RST  = CLEAR_ON_RESET ? S_INIT : S_IDLE;

   localparam logic [2:0] CNT_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [31:0]       r_mem [DEPTH];
   logic [1:0]        r_state;
   logic [2:0]        r_cnt;
   logic [IDX_W-1:0]  r_init_idx;
   logic              r_we;
   logic              r_uns;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_err;

   logic [1:0]        w_next;
   logic              w_accept;
   logic              w_enter_resp;
   logic              w_a_we;
   logic              w_a_uns;
   logic [1:0]        w_a_size;
   logic [ADDR_W-1:0] w_a_addr;
   logic [31:0]       w_a_wdata;
   logic              w_a_err;
   logic [IDX_W-1:0]  w_idx;
   logic [31:0]       w_word;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_merged;
   logic [31:0]       w_load;
   logic              w_commit;
   logic              w_unused;

   assign o_ready  = (r_state == S_IDLE) || (r_state == S_RESP);
   assign o_busy   = (r_state != S_IDLE);
   assign o_done   = (r_state == S_RESP);
   assign o_rData  = r_rdata;
   assign o_err    = r_err;
   assign w_accept = i_req && o_ready;
   assign w_unused = ^i_addr[31:ADDR_W];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT: begin
            if (r_init_idx == '1) w_next = S_IDLE;
         end
         S_IDLE, S_RESP: begin
            if (w_accept) w_next = (LATENCY > 0) ? S_WAIT : S_RESP;
            else          w_next = S_IDLE;
         end
         S_WAIT: begin
            if (r_cnt == CNT_LAST) w_next = S_RESP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_enter_resp = (w_next == S_RESP);

   // With no wait states the access happens on the accepting edge, so the live request is used directly.
   assign w_a_we    = (LATENCY == 0) ? i_we                 : r_we;
   assign w_a_uns   = (LATENCY == 0) ? i_unsigned           : r_uns;
   assign w_a_size  = (LATENCY == 0) ? i_size               : r_size;
   assign w_a_addr  = (LATENCY == 0) ? i_addr[ADDR_W-1:0]   : r_addr;
   assign w_a_wdata = (LATENCY == 0) ? i_wData              : r_wdata;

   assign w_idx  = w_a_addr[ADDR_W-1:2];
   assign w_word = r_mem[w_idx];
   assign w_byte = w_word[{w_a_addr[1:0], 3'b000} +: 8];
   assign w_half = w_word[{w_a_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_a_err = 1'b0;
      case (w_a_size)
         SZ_BYTE: w_a_err = 1'b0;
         SZ_HALF: w_a_err = w_a_addr[0];
         SZ_WORD: w_a_err = (w_a_addr[1:0] != 2'b00);
         default: w_a_err = 1'b1;
      endcase
   end

   always_comb begin
      w_merged = w_word;
      case (w_a_size)
         SZ_BYTE: w_merged[{w_a_addr[1:0], 3'b000} +: 8] = w_a_wdata[7:0];
         SZ_HALF: w_merged[{w_a_addr[1], 4'b0000} +: 16] = w_a_wdata[15:0];
         default: w_merged = w_a_wdata;
      endcase
   end

   always_comb begin
      w_load = w_word;
      case (w_a_size)
         SZ_BYTE: w_load = w_a_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_HALF: w_load = w_a_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = w_word;
      endcase
   end

   assign w_commit = w_enter_resp && w_a_we && !w_a_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_RST;
         r_cnt      <= 3'd0;
         r_init_idx <= '0;
         r_we       <= 1'b0;
         r_uns      <= 1'b0;
         r_size     <= 2'b00;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_rdata    <= 32'd0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_INIT) r_init_idx <= r_init_idx + 1'b1;
         if (w_accept) begin
            r_we    <= i_we;
            r_uns   <= i_unsigned;
            r_size  <= i_size;
            r_addr  <= i_addr[ADDR_W-1:0];
            r_wdata <= i_wData;
            r_cnt   <= 3'd0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 3'd1;
         end
         if (w_enter_resp) begin
            r_err   <= w_a_err;
            r_rdata <= (w_a_err || w_a_we) ? 32'd0 : w_load;
         end
      end
   end

   // Array is never reset so contents survive rst when the clear sweep is disabled.
   always_ff @(posedge clk) begin
      if (r_state == S_INIT) r_mem[r_init_idx] <= 32'd0;
      else if (w_commit)     r_mem[w_idx]      <= w_merged;
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - scoreboard bench for data_mem_unit across three parameter sets
// dut0: ADDR_W=6 LATENCY=3 clear; dut1: ADDR_W=10 LATENCY=0 clear; dut2: ADDR_W=6 LATENCY=5 no clear.
module tb_data_mem_unit;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst   [3];
   logic        req   [3];
   logic        we    [3];
   logic [1:0]  size  [3];
   logic        uns   [3];
   logic [31:0] addr  [3];
   logic [31:0] wdat  [3];
   logic        ready [3];
   logic        done  [3];
   logic [31:0] rdata [3];
   logic        err   [3];
   logic        busy  [3];

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   exp_t mon_e;
   bit   mon_have;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   data_mem_unit #(.ADDR_W(6), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) u_dut0 (
      .clk(clk), .rst(rst[0]), .i_req(req[0]), .i_we(we[0]), .i_size(size[0]),
      .i_unsigned(uns[0]), .i_addr(addr[0]), .i_wData(wdat[0]), .o_ready(ready[0]),
      .o_done(done[0]), .o_rData(rdata[0]), .o_err(err[0]), .o_busy(busy[0]));

   data_mem_unit #(.ADDR_W(10), .LATENCY(0), .CLEAR_ON_RESET(1'b1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .i_req(req[1]), .i_we(we[1]), .i_size(size[1]),
      .i_unsigned(uns[1]), .i_addr(addr[1]), .i_wData(wdat[1]), .o_ready(ready[1]),
      .o_done(done[1]), .o_rData(rdata[1]), .o_err(err[1]), .o_busy(busy[1]));

   data_mem_unit #(.ADDR_W(6), .LATENCY(5), .CLEAR_ON_RESET(1'b0)) u_dut2 (
      .clk(clk), .rst(rst[2]), .i_req(req[2]), .i_we(we[2]), .i_size(size[2]),
      .i_unsigned(uns[2]), .i_addr(addr[2]), .i_wData(wdat[2]), .o_ready(ready[2]),
      .o_done(done[2]), .o_rData(rdata[2]), .o_err(err[2]), .o_busy(busy[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   function automatic int qsize(input int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic push(input int d, input exp_t e);
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
   task automatic issue(input int d, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee, input bit expect_resp);
      int n = 0;
      req[d] = 1'b1; we[d] = w; size[d] = s; uns[d] = u; addr[d] = a; wdat[d] = wd;
      while (ready[d] !== 1'b1 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (ready[d] !== 1'b1) fail_now($sformatf("accept_timeout_dut%0d", d));
      if (expect_resp) push(d, '{d: ed, e: ee});
      @(posedge clk); #1;
      req[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      int n = 0;
      while (qsize(d) != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (qsize(d) != 0) fail_now($sformatf("drain_dut%0d", d));
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (done[d] === 1'b1) begin
            mon_have = 1'b0;
            case (d)
               0: if (q0.size() != 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
               1: if (q1.size() != 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
               default: if (q2.size() != 0) begin mon_e = q2.pop_front(); mon_have = 1'b1; end
            endcase
            if (!mon_have) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done_dut%0d: got o_done=1, expected no response", d);
            end else begin
               check($sformatf("rdata_dut%0d", d), rdata[d], mon_e.d);
               check($sformatf("err_dut%0d", d), 32'(err[d]), 32'(mon_e.e));
            end
         end
      end
   end

   initial begin
      int n;
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'b00;
         uns[d] = 1'b0; addr[d] = 32'd0; wdat[d] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_done_dut%0d", d), 32'(done[d]), 32'd0);
         check($sformatf("rst_rdata_dut%0d", d), rdata[d], 32'd0);
         check($sformatf("rst_err_dut%0d", d), 32'(err[d]), 32'd0);
      end
      check("rst_ready_dut0", 32'(ready[0]), 32'd0);
      check("rst_busy_dut0", 32'(busy[0]), 32'd1);
      check("rst_ready_dut2", 32'(ready[2]), 32'd1);
      check("rst_busy_dut2", 32'(busy[2]), 32'd0);

      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      n = 0;
      while (ready[0] !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("init_cycles_dut0", 32'(n), 32'd16);

      // dut0 functional vectors
      issue(0, 1'b0, SZ_W, 1'b0, 32'h3C, 32'h0,         32'h00000000, 1'b0, 1'b1);
      issue(0, 1'b1, SZ_W, 1'b0, 32'h08, 32'h11223344,  32'h00000000, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_B, 1'b1, 32'h09, 32'h0,         32'h00000033, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_H, 1'b0, 32'h0A, 32'h0,         32'h00001122, 1'b0, 1'b1);
      issue(0, 1'b1, SZ_B, 1'b0, 32'h0B, 32'h123456F0,  32'h00000000, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_B, 1'b0, 32'h0B, 32'h0,         32'hFFFFFFF0, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_W, 1'b0, 32'h08, 32'h0,         32'hF0223344, 1'b0, 1'b1);
      issue(0, 1'b1, SZ_W, 1'b0, 32'h04, 32'h55667788,  32'h00000000, 1'b0, 1'b1);
      issue(0, 1'b1, SZ_W, 1'b0, 32'h06, 32'hDEADBEEF,  32'h00000000, 1'b1, 1'b1);
      issue(0, 1'b0, SZ_W, 1'b0, 32'h04, 32'h0,         32'h55667788, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_X, 1'b0, 32'h04, 32'h0,         32'h00000000, 1'b1, 1'b1);
      issue(0, 1'b1, SZ_H, 1'b0, 32'h02, 32'hABCD8001,  32'h00000000, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_H, 1'b0, 32'h02, 32'h0,         32'hFFFF8001, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_H, 1'b1, 32'h02, 32'h0,         32'h00008001, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_W, 1'b0, 32'h00, 32'h0,         32'h80010000, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_H, 1'b0, 32'h01, 32'h0,         32'h00000000, 1'b1, 1'b1);
      issue(0, 1'b0, SZ_W, 1'b0, 32'h48, 32'h0,         32'hF0223344, 1'b0, 1'b1);
      issue(0, 1'b1, SZ_B, 1'b0, 32'h7F, 32'h000000AA,  32'h00000000, 1'b0, 1'b1);
      issue(0, 1'b0, SZ_W, 1'b0, 32'h3C, 32'h0,         32'hAA000000, 1'b0, 1'b1);
      drain(0);

      // dut0 latency: accept in cycle 0, done in cycle 4; back-to-back accept in 4, done in 8
      @(posedge clk); #1;
      issue(0, 1'b0, SZ_W, 1'b0, 32'h08, 32'h0, 32'hF0223344, 1'b0, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("lat_ready_c%0d", c), 32'(ready[0]), 32'd0);
         check($sformatf("lat_done_c%0d", c), 32'(done[0]), 32'd0);
         @(posedge clk); #1;
      end
      check("lat_done_c4", 32'(done[0]), 32'd1);
      issue(0, 1'b0, SZ_W, 1'b0, 32'h04, 32'h0, 32'h55667788, 1'b0, 1'b1);
      for (int c = 5; c <= 7; c++) begin
         check($sformatf("lat_ready_c%0d", c), 32'(ready[0]), 32'd0);
         @(posedge clk); #1;
      end
      check("lat_done_c8", 32'(done[0]), 32'd1);
      drain(0);

      // dut1: wrap plus load in the RESP cycle of a same-address store
      issue(1, 1'b1, SZ_W, 1'b0, 32'h408, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b1);
      check("b2b_ready_dut1", 32'(ready[1]), 32'd1);
      check("b2b_done_dut1", 32'(done[1]), 32'd1);
      issue(1, 1'b0, SZ_W, 1'b0, 32'h008, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
      check("b2b_done2_dut1", 32'(done[1]), 32'd1);
      issue(1, 1'b0, SZ_B, 1'b1, 32'h00B, 32'h0, 32'h000000CA, 1'b0, 1'b1);
      drain(1);

      // dut2: reset during WAIT drops the pending store; contents persist
      issue(2, 1'b1, SZ_W, 1'b0, 32'h10, 32'h00000001, 32'h00000000, 1'b0, 1'b1);
      drain(2);
      issue(2, 1'b1, SZ_W, 1'b0, 32'h10, 32'h00000002, 32'h00000000, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst[2] = 1'b1;
      #1;
      check("midwait_rst_ready", 32'(ready[2]), 32'd1);
      check("midwait_rst_busy", 32'(busy[2]), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midwait_idle_busy", 32'(busy[2]), 32'd0);
      issue(2, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h00000001, 1'b0, 1'b1);
      drain(2);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
